// File: rtl/mbist_controller.sv
// March C- memory BIST controller.
//
// On an accepted start it takes the memory through the normal/BIST mux
// (NbarT=1), runs the six March C- elements with all-zeros/all-ones
// patterns, and checks the returned read data through a one-deep check
// stage. When the test finishes it gives the memory back (NbarT=0) and
// holds done, the sticky fail flag and the first failing address.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   start      one-cycle request, honoured only in IDLE or DONE
//   data_in    memory read data, valid the cycle after a re cycle
//   NbarT      mux select, 1 = BIST owns the memory
//   addr_out   BIST address
//   data_out   BIST write data
//   we         BIST write enable
//   re         BIST read enable
//   done       test complete (level)
//   fail       sticky mismatch flag for the current run
//   fail_addr  address of the first mismatch, valid when fail=1
module mbist_controller #(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned WIDTH      = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      data_in,
    output logic                  NbarT,
    output logic [ADDR_WIDTH-1:0] addr_out,
    output logic [WIDTH-1:0]      data_out,
    output logic                  we,
    output logic                  re,
    output logic                  done,
    output logic                  fail,
    output logic [ADDR_WIDTH-1:0] fail_addr
);

    localparam logic [3:0] StIdle  = 4'd0;
    localparam logic [3:0] StM0    = 4'd1;
    localparam logic [3:0] StM1    = 4'd2;
    localparam logic [3:0] StM2    = 4'd3;
    localparam logic [3:0] StM3    = 4'd4;
    localparam logic [3:0] StM4    = 4'd5;
    localparam logic [3:0] StM5    = 4'd6;
    localparam logic [3:0] StFlush = 4'd7;
    localparam logic [3:0] StDone  = 4'd8;

    localparam logic PhRead  = 1'b0;
    localparam logic PhWrite = 1'b1;

    localparam logic [ADDR_WIDTH-1:0] AddrMax = {ADDR_WIDTH{1'b1}};
    localparam logic [ADDR_WIDTH-1:0] AddrMin = {ADDR_WIDTH{1'b0}};

    logic [3:0]            state_q, state_d;
    logic                  phase_q, phase_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;

    logic                  nbart_q, nbart_d;
    logic [ADDR_WIDTH-1:0] addr_out_q, addr_out_d;
    logic [WIDTH-1:0]      data_out_q, data_out_d;
    logic                  we_q, we_d;
    logic                  re_q, re_d;
    logic                  done_q, done_d;
    logic                  fail_q, fail_d;
    logic [ADDR_WIDTH-1:0] fail_addr_q, fail_addr_d;

    // Check stage: one outstanding read, its expected pattern and address.
    logic                  chk_valid_q, chk_valid_d;
    logic                  chk_ones_q, chk_ones_d;
    logic [ADDR_WIDTH-1:0] chk_addr_q, chk_addr_d;

    logic accept;
    logic is_op_d;
    logic two_op_d;

    assign accept = start && ((state_q == StIdle) || (state_q == StDone));

    // Sequencer: state, read/write phase and address for the next cycle.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        addr_d  = addr_q;
        case (state_q)
            StIdle, StDone: begin
                if (accept) begin
                    state_d = StM0;
                    phase_d = PhRead;
                    addr_d  = AddrMin;
                end
            end
            StM0: begin
                if (addr_q == AddrMax) begin
                    state_d = StM1;
                    addr_d  = AddrMin;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            StM1, StM2: begin
                if (phase_q == PhRead) begin
                    phase_d = PhWrite;
                end else begin
                    phase_d = PhRead;
                    if (addr_q == AddrMax) begin
                        if (state_q == StM1) begin
                            state_d = StM2;
                            addr_d  = AddrMin;
                        end else begin
                            state_d = StM3;
                            addr_d  = AddrMax;
                        end
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end
            end
            StM3, StM4: begin
                if (phase_q == PhRead) begin
                    phase_d = PhWrite;
                end else begin
                    phase_d = PhRead;
                    if (addr_q == AddrMin) begin
                        state_d = (state_q == StM3) ? StM4 : StM5;
                        addr_d  = AddrMax;
                    end else begin
                        addr_d = addr_q - 1'b1;
                    end
                end
            end
            StM5: begin
                if (addr_q == AddrMin) begin
                    state_d = StFlush;
                end else begin
                    addr_d = addr_q - 1'b1;
                end
            end
            StFlush: state_d = StDone;
            default: state_d = StIdle;
        endcase
    end

    // Registered outputs are decoded from the next state so they line up with
    // the sequencer registers.
    always_comb begin
        is_op_d  = (state_d >= StM0) && (state_d <= StM5);
        two_op_d = (state_d >= StM1) && (state_d <= StM4);
        nbart_d  = (state_d != StIdle) && (state_d != StDone);
        done_d   = (state_d == StDone);
        we_d     = (state_d == StM0) || (two_op_d && (phase_d == PhWrite));
        re_d     = (state_d == StM5) || (two_op_d && (phase_d == PhRead));
        addr_out_d = is_op_d ? addr_d : AddrMin;
        // M1 and M3 write ones; M0, M2, M4 write zeros.
        if (we_d && ((state_d == StM1) || (state_d == StM3))) begin
            data_out_d = {WIDTH{1'b1}};
        end else begin
            data_out_d = {WIDTH{1'b0}};
        end
    end

    // Check pipeline: capture the read issued this cycle, compare the read
    // captured last cycle against data_in.
    always_comb begin
        chk_valid_d = re_q;
        chk_ones_d  = (state_q == StM2) || (state_q == StM4);
        chk_addr_d  = addr_out_q;
        fail_d      = fail_q;
        fail_addr_d = fail_addr_q;
        if (chk_valid_q && (data_in != {WIDTH{chk_ones_q}})) begin
            fail_d = 1'b1;
            if (!fail_q) begin
                fail_addr_d = chk_addr_q;
            end
        end
        if (accept) begin
            chk_valid_d = 1'b0;
            fail_d      = 1'b0;
            fail_addr_d = AddrMin;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            phase_q     <= PhRead;
            addr_q      <= AddrMin;
            nbart_q     <= 1'b0;
            addr_out_q  <= AddrMin;
            data_out_q  <= {WIDTH{1'b0}};
            we_q        <= 1'b0;
            re_q        <= 1'b0;
            done_q      <= 1'b0;
            fail_q      <= 1'b0;
            fail_addr_q <= AddrMin;
            chk_valid_q <= 1'b0;
            chk_ones_q  <= 1'b0;
            chk_addr_q  <= AddrMin;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            addr_q      <= addr_d;
            nbart_q     <= nbart_d;
            addr_out_q  <= addr_out_d;
            data_out_q  <= data_out_d;
            we_q        <= we_d;
            re_q        <= re_d;
            done_q      <= done_d;
            fail_q      <= fail_d;
            fail_addr_q <= fail_addr_d;
            chk_valid_q <= chk_valid_d;
            chk_ones_q  <= chk_ones_d;
            chk_addr_q  <= chk_addr_d;
        end
    end

    assign NbarT     = nbart_q;
    assign addr_out  = addr_out_q;
    assign data_out  = data_out_q;
    assign we        = we_q;
    assign re        = re_q;
    assign done      = done_q;
    assign fail      = fail_q;
    assign fail_addr = fail_addr_q;

endmodule

// File: tb/tb_mbist_controller.sv
// Bench for mbist_controller with ADDR_WIDTH=4, WIDTH=8 and a synchronous
// memory model that can carry a stuck-at or a coupling fault.
module tb_mbist_controller;

    localparam int AW = 4;
    localparam int DW = 8;
    localparam int NOPS = 160;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic          NbarT;
    logic [AW-1:0] addr_out;
    logic [DW-1:0] data_out;
    logic          we;
    logic          re;
    logic          done;
    logic          fail;
    logic [AW-1:0] fail_addr;

    int checks = 0;
    int errors = 0;

    // 0 = fault-free, 1 = bit0 stuck-at-1 at addr 5, 2 = write of 9 flips 3
    int fault_mode = 0;
    logic [DW-1:0] mem [16];

    logic [16:0] q [$];
    int nk;
    int cur_ffi;

    mbist_controller #(
        .ADDR_WIDTH(AW),
        .WIDTH     (DW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .data_in  (data_in),
        .NbarT    (NbarT),
        .addr_out (addr_out),
        .data_out (data_out),
        .we       (we),
        .re       (re),
        .done     (done),
        .fail     (fail),
        .fail_addr(fail_addr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (re) begin
            data_in <= mem[addr_out] | ((fault_mode == 1 && addr_out == 4'd5) ? 8'h01 : 8'h00);
        end
        if (we) begin
            mem[addr_out] <= data_out;
            if (fault_mode == 2 && addr_out == 4'd9) begin
                mem[3] <= ~mem[3];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [16:0] obs_vec();
        return {NbarT, we, re, done, fail, addr_out, data_out};
    endfunction

    function automatic logic fexp(input int k);
        return (cur_ffi >= 0) && (k >= cur_ffi + 2);
    endfunction

    // Expected outputs for sample k: {NbarT, we, re, done, fail, addr, data}
    task automatic push_op(input logic w, input logic r, input int a, input logic [7:0] d);
        logic [3:0] aa;
        aa = 4'(a);
        q.push_back({1'b1, w, r, 1'b0, fexp(nk), aa, d});
        nk++;
    endtask

    task automatic build_march(input int ffi);
        q.delete();
        nk = 0;
        cur_ffi = ffi;
        for (int a = 0; a < 16; a++) push_op(1'b1, 1'b0, a, 8'h00);
        for (int a = 0; a < 16; a++) begin
            push_op(1'b0, 1'b1, a, 8'h00);
            push_op(1'b1, 1'b0, a, 8'hFF);
        end
        for (int a = 0; a < 16; a++) begin
            push_op(1'b0, 1'b1, a, 8'h00);
            push_op(1'b1, 1'b0, a, 8'h00);
        end
        for (int a = 15; a >= 0; a--) begin
            push_op(1'b0, 1'b1, a, 8'h00);
            push_op(1'b1, 1'b0, a, 8'hFF);
        end
        for (int a = 15; a >= 0; a--) begin
            push_op(1'b0, 1'b1, a, 8'h00);
            push_op(1'b1, 1'b0, a, 8'h00);
        end
        for (int a = 15; a >= 0; a--) push_op(1'b0, 1'b1, a, 8'h00);
        // FLUSH then DONE
        q.push_back({1'b1, 1'b0, 1'b0, 1'b0, fexp(NOPS), 4'h0, 8'h00});
        q.push_back({1'b0, 1'b0, 1'b0, 1'b1, fexp(NOPS + 1), 4'h0, 8'h00});
    endtask

    // Full run from IDLE/DONE; pa/pb are sample indices at which a stray
    // start pulse is driven (-1 for none).
    task automatic run(input string tag, input int ffi, input int pa, input int pb,
                       input logic [3:0] exp_fa);
        logic [16:0] e;
        build_march(ffi);
        @(negedge clk);
        start = 1'b1;
        for (int k = 0; k < NOPS + 2; k++) begin
            @(negedge clk);
            start = (k == pa) || (k == pb);
            e = q.pop_front();
            chk($sformatf("%s op%0d", tag, k), 32'(obs_vec()), 32'(e));
        end
        start = 1'b0;
        chk($sformatf("%s fail_addr", tag), 32'(fail_addr), 32'(exp_fa));
        chk($sformatf("%s fail", tag), 32'(fail), 32'(ffi >= 0));
        // Levels hold in DONE.
        repeat (3) @(negedge clk);
        chk($sformatf("%s hold", tag), 32'({done, NbarT, fail, fail_addr}),
            32'({1'b1, 1'b0, ffi >= 0, exp_fa}));
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = '0;

        // Reset held with a start pulse: ignored.
        start = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_outputs", 32'({obs_vec(), fail_addr}), 32'd0);
        start = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("idle%0d", i), 32'({obs_vec(), fail_addr}), 32'd0);
        end

        // Fault-free run, with stray starts mid-run and in FLUSH.
        run("clean", -1, 50, NOPS, 4'd0);

        // Stuck-at at address 5: first failing read is M1 read of 5.
        fault_mode = 1;
        run("stuck", 16 + 2 * 5, -1, -1, 4'd5);

        // Restart from DONE after a failing run, memory now clean.
        fault_mode = 0;
        run("rerun", -1, -1, -1, 4'd0);

        // Coupling: writing 9 in M0 flips 3; caught at M1 read of 3.
        fault_mode = 2;
        run("coupling", 16 + 2 * 3, -1, -1, 4'd3);
        fault_mode = 0;

        // Asynchronous reset in the middle of a run.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (39) @(negedge clk);
        chk("pre_rst_nbart", 32'(NbarT), 32'd1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 chk("async_rst", 32'({NbarT, we, re, done, fail}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        chk("post_rst", 32'({obs_vec(), fail_addr}), 32'd0);
        run("after_rst", -1, -1, -1, 4'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mbist_controller.md
# mbist_controller

March C- memory BIST controller: the test-side driver of the normal/BIST input multiplexer in front of each memory under test. On a start pulse it takes the memory (NbarT=1), sequences addresses and write data through the mux's bist inputs, and checks read data returned by the memory. It reports done, a sticky fail flag and the first failing address. Afterwards it releases the memory to normal mode.

## Interface
- ADDR_WIDTH, 4: memory address width; DEPTH = 2**ADDR_WIDTH words.
- WIDTH, 10: memory data width; matches the mux WIDTH.

- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request; honoured only in IDLE or DONE.
- data_in  input  WIDTH  memory read data, valid the cycle after a re cycle.
- NbarT  output  1  mux select: 1 = BIST owns memory, 0 = normal.
- addr_out  output  ADDR_WIDTH  BIST address to mux.
- data_out  output  WIDTH  BIST write data to mux.
- we  output  1  BIST write enable.
- re  output  1  BIST read enable.
- done  output  1  test complete; level, held until next accepted start or reset.
- fail  output  1  sticky mismatch flag for current run.
- fail_addr  output  ADDR_WIDTH  address of first mismatch; valid when fail=1.

## Operation
- All outputs registered. Reset: state IDLE, NbarT=0, addr_out=0, data_out=0, we=0, re=0, done=0, fail=0, fail_addr=0.
- States: IDLE, M0..M5, FLUSH, DONE. M1..M4 carry a phase bit (READ, then WRITE).
- March C- elements, pattern 0 = all zeros, 1 = all ones of WIDTH bits:
  - M0 up: w0.
  - M1 up: r0,w1.
  - M2 up: r1,w0.
  - M3 down: r0,w1.
  - M4 down: r1,w0.
  - M5 down: r0.
- Up = address 0 to DEPTH-1; down = DEPTH-1 to 0.
- One operation per cycle:
  - Write cycle: we=1, re=0, data_out=pattern.
  - Read cycle: re=1, we=0, data_out=0.
- Two-op elements: READ then WRITE at the same address, then advance address.
- Element transition: on the last address of an element, advance to the next element at its start address (0 for up, DEPTH-1 for down). No wrap within an element.
- After M5's last read: FLUSH (NbarT=1, we=re=0), then DONE.
  - DONE: NbarT=0, done=1.
  - addr_out and data_out return to 0.
- Check pipeline:
  - Each read cycle registers expected pattern and address into a one-deep check stage.
  - At the edge ending the following cycle, data_in is compared with the expected pattern.
  - On mismatch: fail<=1; if fail was 0, fail_addr<=checked address. Later mismatches do not overwrite.
- The test runs to completion regardless of failures.
- start in IDLE or DONE: next state M0, addr 0, done<=0, fail<=0, fail_addr<=0, check stage cleared.
- start in any other state is ignored.
- rst mid-run: immediate return to reset values; memory is released (NbarT=0) without waiting for a clock.
- rst and start together: rst wins.

## Timing
- Accepting edge E0 (start=1 sampled in IDLE/DONE): after E0, NbarT=1 and the first M0 write is on the outputs.
- Operation count: 10*DEPTH ops, occupying the cycles after edges E0 .. E0+10*DEPTH-1.
- The last read's data is checked at edge E0+10*DEPTH+1.
  - FLUSH follows edge E0+10*DEPTH.
  - DONE (done=1, NbarT=0, final fail/fail_addr) follows edge E0+10*DEPTH+1.
- Latency start to done: 10*DEPTH+1 edges; DEPTH=16 gives 161.
- fail updates exactly two edges after the edge that drove the corresponding re=1.
- Memory is assumed synchronous: reads return data the next cycle; writes take effect at the edge ending the we cycle.

## Test plan
- Reset, no start → NbarT=0, we=re=0, done=0, fail=0 indefinitely; start pulse during rst=1 ignored.
- ADDR_WIDTH=4, WIDTH=8, fault-free memory model, start pulse → done rises 161 edges later, fail=0, NbarT=0. Logged ops: 16 writes of 0x00 up; then r0/w1 pairs at 0..15; ...; last op r0 at address 0.
- Bit 0 stuck-at-1 at address 5 → first check failure is the M1 read of 5 (reads 0x01); fail=1, fail_addr=5. Values hold after done, although M3/M5 reads of 5 also mismatch.
- Coupling fault where writing address 9 flips address 3 → fail_addr=3 reported at the first affected read, fail sticky.
- rst pulse at cycle 40 of a run → NbarT, we, re drop asynchronously before the next edge. A fresh start then completes in 161 edges with fail=0.
- start pulses during run and in FLUSH → ignored, timing unchanged. start in DONE after a failing run → done and fail clear on the next edge and a full run repeats.
